// File: rtl/pkt_pre_arbiter.sv
// Per-port ingress buffer: stores frame bytes in a circular RAM and queues descriptors.
// Optional MIN_LEN_FILTER_EN also drops frames shorter than 64 bytes.
module pkt_pre_arbiter #(
    parameter int pFIFO_WIDTH = 11,
    parameter int pDEPTH_RAM  = 2048,
    parameter int pDESC_DEPTH = 8,
    parameter int pMAX_LEN    = 1518,
    localparam int AW = $clog2(pDEPTH_RAM),
    localparam int DW = $clog2(pDESC_DEPTH)
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   i_w_permition,
    input  logic                   idv,
    input  logic                   i_error,
    input  logic [7:0]             irx_d,
    input  logic [2:0]             iFSM_state,
    input  logic [1:0]             i_port_num,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [7:0]             o_rd_data,
    output logic [pFIFO_WIDTH-1:0] o_length,
    output logic [1:0]             o_port_num,
    output logic [AW-1:0]          o_start_adress,
    output logic                   o_request
);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_COMMIT} state_t;

    typedef struct packed {
        logic [pFIFO_WIDTH-1:0] len;
        logic [1:0]             port;
        logic [AW-1:0]          start;
    } desc_t;

    localparam logic [pFIFO_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [pFIFO_WIDTH-1:0] CNT_ONE = pFIFO_WIDTH'(1);
    localparam logic [pFIFO_WIDTH-1:0] MAX_L   = pFIFO_WIDTH'(pMAX_LEN);
    localparam logic [pFIFO_WIDTH-1:0] MIN_L   = pFIFO_WIDTH'(64);
    localparam logic [AW-1:0]          LAST_A  = AW'(pDEPTH_RAM - 1);
    localparam logic [DW:0]            F_FULL  = (DW+1)'(pDESC_DEPTH);
    localparam logic [DW:0]            F_ONE   = (DW+1)'(1);
    localparam logic [DW-1:0]          P_ONE   = DW'(1);

    logic [7:0] ram [pDEPTH_RAM];
    desc_t      fifo_mem [pDESC_DEPTH];

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          start_q, start_d;
    logic [1:0]             port_q, port_d;
    logic [pFIFO_WIDTH-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [DW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [DW:0]   fcnt_q, fcnt_d;

    logic                   req_q;
    logic [pFIFO_WIDTH-1:0] len_q;
    logic [1:0]             oport_q;
    logic [AW-1:0]          ostart_q;
    logic [7:0]             rd_data_q;

    logic          rx_bad, full, push, issue, frame_start, good;
    logic          ram_we;
    logic [AW-1:0] ram_waddr, base;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_A) ? '0 : a + AW'(1);
    endfunction

    assign rx_bad = i_error | (iFSM_state == 3'd7);
    assign full   = (fcnt_q == F_FULL);
    assign issue  = (fcnt_q != '0) && (i_w_permition == 1'b1) && !req_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_d     = start_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        ram_we      = 1'b0;
        ram_waddr   = wr_ptr_q;
        push        = 1'b0;
        good        = 1'b0;
        frame_start = 1'b0;
        base        = wr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                frame_start = idv;
            end
            ST_RECV: begin
                if (idv) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = next_addr(wr_ptr_q);
                    err_d    = err_q | rx_bad;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
`ifdef MIN_LEN_FILTER_EN
                good = !err_q && (cnt_q <= MAX_L) && (cnt_q >= MIN_L) && !full;
`else
                good = !err_q && (cnt_q <= MAX_L) && !full;
`endif
                push        = good;
                // A dropped frame hands its space back to the next one
                base        = good ? wr_ptr_q : start_q;
                wr_ptr_d    = base;
                state_d     = ST_IDLE;
                frame_start = idv;
            end
            default: state_d = ST_IDLE;
        endcase
        if (frame_start) begin
            start_d   = base;
            port_d    = i_port_num;
            ram_we    = 1'b1;
            ram_waddr = base;
            wr_ptr_d  = next_addr(base);
            cnt_d     = CNT_ONE;
            err_d     = rx_bad;
            state_d   = ST_RECV;
        end
    end

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        fcnt_d = fcnt_q;
        if (push)  wp_d = wp_q + P_ONE;
        if (issue) rp_d = rp_q + P_ONE;
        unique case ({push, issue})
            2'b10:   fcnt_d = fcnt_q + F_ONE;
            2'b01:   fcnt_d = fcnt_q - F_ONE;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            start_q   <= '0;
            port_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            fcnt_q    <= '0;
            req_q     <= 1'b0;
            len_q     <= '0;
            oport_q   <= '0;
            ostart_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            start_q   <= start_d;
            port_q    <= port_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            fcnt_q    <= fcnt_d;
            req_q     <= issue;
            rd_data_q <= ram[i_rd_addr];
            if (issue) begin
                len_q    <= fifo_mem[rp_q].len;
                oport_q  <= fifo_mem[rp_q].port;
                ostart_q <= fifo_mem[rp_q].start;
            end
        end
    end

    // Storage arrays carry no reset; contents survive i_rst
    always_ff @(posedge iclk) begin
        if (ram_we) ram[ram_waddr] <= irx_d;
        if (push)   fifo_mem[wp_q] <= '{len: cnt_q, port: port_q, start: start_q};
    end

    assign o_rd_data      = rd_data_q;
    assign o_length       = len_q;
    assign o_port_num     = oport_q;
    assign o_start_adress = ostart_q;
    assign o_request      = req_q;

endmodule

// File: tb/tb_pkt_pre_arbiter.sv
// Directed bench for pkt_pre_arbiter: vector table plus multi-frame sequences.
module tb_pkt_pre_arbiter;

    localparam int AW = 11;

    logic          iclk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_w_permition = 1'b0;
    logic          idv = 1'b0;
    logic          i_error = 1'b0;
    logic [7:0]    irx_d = '0;
    logic [2:0]    iFSM_state = '0;
    logic [1:0]    i_port_num = '0;
    logic [AW-1:0] i_rd_addr = '0;
    logic [7:0]    o_rd_data;
    logic [10:0]   o_length;
    logic [1:0]    o_port_num;
    logic [AW-1:0] o_start_adress;
    logic          o_request;

    pkt_pre_arbiter dut (
        .iclk           (iclk),
        .i_rst          (i_rst),
        .i_w_permition  (i_w_permition),
        .idv            (idv),
        .i_error        (i_error),
        .irx_d          (irx_d),
        .iFSM_state     (iFSM_state),
        .i_port_num     (i_port_num),
        .i_rd_addr      (i_rd_addr),
        .o_rd_data      (o_rd_data),
        .o_length       (o_length),
        .o_port_num     (o_port_num),
        .o_start_adress (o_start_adress),
        .o_request      (o_request)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int len;
        int port;
        int errpos;
        bit fsm;
        bit issue;
        int start;
    } vec_t;

    typedef struct {
        int len;
        int port;
        int start;
        int cyc;
    } req_t;

    req_t rq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    vec_t vt[7];

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk)
        if (o_request)
            rq.push_back('{int'(o_length), int'(o_port_num),
                           int'(o_start_adress), cyc});

    function automatic logic [7:0] byte_of(input int seed, input int k);
        return 8'(seed * 37 + k * 5 + 3);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_frame(input int len, input int port, input int errpos,
                              input bit fsm, input int seed);
        for (int k = 0; k < len; k++) begin
            @(negedge iclk);
            idv        = 1'b1;
            irx_d      = byte_of(seed, k);
            i_port_num = (k == 0) ? 2'(port) : ~2'(port);
            i_error    = (k == errpos) && !fsm;
            iFSM_state = ((k == errpos) && fsm) ? 3'd7 : 3'd2;
        end
        @(negedge iclk);
        idv        = 1'b0;
        i_error    = 1'b0;
        iFSM_state = 3'd0;
        irx_d      = '0;
    endtask

    task automatic check_req(input string nm, input int len, input int port,
                             input int start, output int c);
        req_t r;
        c = -1;
        if (rq.size() == 0) begin
            chk({nm, "_present"}, 0, 1);
        end else begin
            r = rq.pop_front();
            c = r.cyc;
            chk({nm, "_len"}, r.len, len);
            chk({nm, "_port"}, r.port, port);
            chk({nm, "_start"}, r.start, start);
        end
    endtask

    task automatic rd_chk(input int addr, input int exp);
        @(negedge iclk);
        i_rd_addr = AW'(addr);
        @(negedge iclk);
        chk($sformatf("rd_data[%0d]", addr), int'(o_rd_data), exp);
    endtask

    task automatic do_reset();
        @(negedge iclk);
        i_rst = 1'b0;
        idv   = 1'b0;
        repeat (3) @(negedge iclk);
        i_rst = 1'b1;
        rq.delete();
    endtask

    initial begin
        int c0, c1, c2;
        vt[0] = '{64,   1, -1, 0, 1, 0};
        vt[1] = '{1600, 2, -1, 0, 0, 0};
        vt[2] = '{1518, 3, -1, 0, 1, 64};
        vt[3] = '{80,   0, 30, 1, 0, 0};
        vt[4] = '{458,  0, -1, 0, 1, 1582};
        vt[5] = '{64,   2, -1, 0, 1, 2040};
`ifdef MIN_LEN_FILTER_EN
        vt[6] = '{40,   1, -1, 0, 0, 0};
`else
        vt[6] = '{40,   1, -1, 0, 1, 56};
`endif

        repeat (2) @(negedge iclk);
        chk("rst_request", int'(o_request), 0);
        chk("rst_length", int'(o_length), 0);
        chk("rst_port", int'(o_port_num), 0);
        chk("rst_start", int'(o_start_adress), 0);
        chk("rst_rd_data", int'(o_rd_data), 0);
        i_rst = 1'b1;
        i_w_permition = 1'b1;
        @(negedge iclk);

        for (int i = 0; i < 7; i++) begin
            send_frame(vt[i].len, vt[i].port, vt[i].errpos, vt[i].fsm, i + 1);
            repeat (8) @(negedge iclk);
            if (vt[i].issue)
                check_req($sformatf("vec%0d", i), vt[i].len, vt[i].port,
                          vt[i].start, c0);
            chk($sformatf("vec%0d_extra", i), rq.size(), 0);
            rq.delete();
            if (i == 0)
                for (int a = 0; a < 64; a++) rd_chk(a, int'(byte_of(1, a)));
        end
        for (int k = 0; k < 64; k++)
            rd_chk((2040 + k) % 2048, int'(byte_of(6, k)));

        do_reset();
        i_w_permition = 1'b0;
        send_frame(64, 0, -1, 0, 10);
        repeat (3) @(negedge iclk);
        send_frame(100, 1, -1, 0, 11);
        repeat (3) @(negedge iclk);
        send_frame(72, 2, -1, 0, 12);
        repeat (10) @(negedge iclk);
        chk("held_no_req", rq.size(), 0);
        i_w_permition = 1'b1;
        repeat (12) @(negedge iclk);
        check_req("acc0", 64, 0, 0, c0);
        check_req("acc1", 100, 1, 64, c1);
        check_req("acc2", 72, 2, 164, c2);
        chk("acc_gap01", c1 - c0, 2);
        chk("acc_gap12", c2 - c1, 2);

        i_w_permition = 1'b0;
        send_frame(64, 3, -1, 0, 20);
        send_frame(64, 1, 10, 0, 21);
        send_frame(64, 2, -1, 0, 22);
        repeat (6) @(negedge iclk);
        chk("b2b_held", rq.size(), 0);
        i_w_permition = 1'b1;
        repeat (10) @(negedge iclk);
        check_req("b2b0", 64, 3, 236, c0);
        check_req("b2b2", 64, 2, 300, c1);
        chk("b2b_extra", rq.size(), 0);

        i_w_permition = 1'b0;
        for (int f = 0; f < 9; f++) begin
            send_frame(64, f % 4, -1, 0, 30 + f);
            repeat (3) @(negedge iclk);
        end
        i_w_permition = 1'b1;
        repeat (25) @(negedge iclk);
        chk("full_count", rq.size(), 8);
        for (int f = 0; f < 8; f++)
            check_req($sformatf("full%0d", f), 64, f % 4, 364 + 64 * f, c0);
        rq.delete();
        send_frame(64, 1, -1, 0, 39);
        repeat (8) @(negedge iclk);
        check_req("after_full", 64, 1, 876, c0);

        for (int k = 0; k < 20; k++) begin
            @(negedge iclk);
            idv        = 1'b1;
            irx_d      = byte_of(45, k);
            i_port_num = 2'd3;
        end
        #2 i_rst = 1'b0;
        #1;
        chk("mid_rst_request", int'(o_request), 0);
        chk("mid_rst_length", int'(o_length), 0);
        chk("mid_rst_start", int'(o_start_adress), 0);
        chk("mid_rst_port", int'(o_port_num), 0);
        idv = 1'b0;
        repeat (3) @(negedge iclk);
        i_rst = 1'b1;
        rq.delete();
        send_frame(64, 2, -1, 0, 40);
        repeat (8) @(negedge iclk);
        check_req("post_rst", 64, 2, 0, c0);
        rd_chk(0, int'(byte_of(40, 0)));
        rd_chk(63, int'(byte_of(40, 63)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_pre_arbiter.md
Name: pkt_pre_arbiter

Overview:
- Per-port ingress stage between the frame receiver and the output arbiter.
- Stores each received frame's bytes into a local circular buffer RAM.
- Builds a descriptor {length, port, start address} per good frame, queues it in a small FIFO, and issues a one-cycle request per descriptor while the arbiter grants work permission.
- Errored or oversize frames are discarded and their buffer space is reclaimed.

Parameters:
- pFIFO_WIDTH, 11: width of the length field (bytes); max counted length 2047.
- pDEPTH_RAM, 2048: buffer RAM depth in bytes; address width is clog2(pDEPTH_RAM).
- pDESC_DEPTH, 8: descriptor FIFO depth (power of two).
- pMAX_LEN, 1518: largest accepted frame length in bytes.

Ports:
- iclk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_w_permition  in  1  arbiter permission to issue requests.
- idv  in  1  receiver data valid; high for every frame byte.
- i_error  in  1  receiver error flag; any high cycle during the frame marks it bad.
- irx_d  in  8  frame byte.
- iFSM_state  in  3  receiver state; 3'd7 = error state, treated like i_error.
- i_port_num  in  2  source port tag, sampled at frame start.
- i_rd_addr  in  clog2(pDEPTH_RAM)  RAM read address.
- o_rd_data  out  8  RAM read data, registered, 1-cycle latency.
- o_length  out  pFIFO_WIDTH  descriptor frame length in bytes.
- o_port_num  out  2  descriptor port tag.
- o_start_adress  out  clog2(pDEPTH_RAM)  descriptor first-byte RAM address.
- o_request  out  1  descriptor-valid strobe.

Behaviour:
- Reset (i_rst=0, async): all of the following clear to 0 and stay 0 until i_rst returns to 1:
  - write pointer, start latch, byte counter, error flag;
  - FIFO pointers and count;
  - o_length, o_port_num, o_start_adress, o_request, o_rd_data.
- Reset does not clear RAM contents.
- Write FSM states:
  - IDLE: on idv=1 →
    - latch start = wr_ptr and port = i_port_num;
    - write irx_d at wr_ptr, wr_ptr+1;
    - count=1, err = i_error | (iFSM_state==7);
    - go to RECV.
  - RECV, idv=1:
    - write byte, wr_ptr+1 with wrap modulo pDEPTH_RAM;
    - count saturates at 2^pFIFO_WIDTH-1;
    - err |= i_error | (iFSM_state==7).
  - RECV, idv=0: go to COMMIT (the frame has ended).
  - COMMIT, single cycle, then IDLE.
    - Good frame: push {count, port, start} if all hold: err==0, count<=pMAX_LEN, FIFO not full.
    - Otherwise drop: restore wr_ptr=start.
- Back-to-back frames: an idv rise during COMMIT is captured as a new frame start in the same cycle. The next start address is the committed wr_ptr, or the restored one if the frame was dropped.
- Buffer overwrite protection: none. Downstream must consume within pDEPTH_RAM bytes of traffic.
- Issue side:
  - When the FIFO is non-empty, i_w_permition=1 and o_request was 0 last cycle: the next cycle drives o_request=1 for exactly one cycle, with o_length/o_port_num/o_start_adress = head descriptor, and pops the FIFO.
  - Descriptor outputs hold their value until the next issue.
  - Back-to-back descriptors issue at most every second cycle.
- i_w_permition=0 or X: no requests issued; descriptors accumulate, up to pDESC_DEPTH.
- Simultaneous push and pop: both occur; count is unchanged.
- Push while full: the frame is dropped, as above.
- RAM: one write port (frame data) and one read port (i_rd_addr → o_rd_data), both on iclk. Read-during-write to the same address returns the old data.

Optional Feature:
- Macro MIN_LEN_FILTER_EN.
- When defined: frames with count < 64 are also dropped at COMMIT, and their space is reclaimed.
- When undefined: any length from 1 to pMAX_LEN is accepted.

Test Plan:
- Reset release, then a 64-byte good frame on port 1 at wr_ptr 0 with i_w_permition=1 → one o_request pulse with o_length=64, o_port_num=1, o_start_adress=0. Reading address 0..63 returns the sent bytes.
- i_w_permition held 0 during 3 frames of 64, 100 and 72 bytes, then raised → 3 requests two cycles apart. Start addresses 0, 64, 164; lengths 64, 100, 72.
- i_error high for one cycle mid-frame in frame 2 of 3 → only frames 1 and 3 issue. Frame 3's start address equals frame 2's start address.
- Frame of 1600 bytes → no request, wr_ptr restored. Frame of 1518 bytes → accepted.
- Writes across the RAM end (start 2040, 64 bytes) → o_start_adress=2040, data wraps to addresses 0..55.
- Assert i_rst=0 mid-frame → o_request=0 and pointers 0 immediately. The next frame starts at address 0.
- With MIN_LEN_FILTER_EN: a 40-byte frame is dropped. Without it: the 40-byte frame issues with o_length=40.
